// File: rtl/moore_non_pkg.sv
// State encoding shared by the 1101 detector and its reference model.
package moore_non_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

endpackage

// File: rtl/moore_non.sv
// Moore detector for serial pattern 1101, non-overlapping; out is decoded from state only.
// out rises after the edge sampling the final 1 and lasts one period; no backpressure.
module moore_non
  import moore_non_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  state_t ps;
  state_t ns;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ps <= S0;
    else       ps <= ns;
  end

  always_comb begin
    ns  = S0;
    out = 1'b0;
    case (ps)
      S0:      ns = in ? S1 : S0;
      S1:      ns = in ? S2 : S0;
      // A third consecutive 1 falls back to idle rather than staying at "11".
      S2:      ns = in ? S0 : S3;
      S3:      ns = in ? S4 : S0;
      // The bit sampled in S4 is dropped so matches never share bits.
      S4:      ns = S0;
      default: ns = S0;
    endcase
    out = (ps == S4);
  end

endmodule

// File: tb/tb_moore_non.sv
// Scoreboarded bench for moore_non: directed sequences with fixed expected flags plus a random run.
module tb_moore_non;
  import moore_non_pkg::*;

  logic clk;
  logic reset;
  logic in;
  logic out;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic   out;
    state_t ps;
    string  tag;
  } exp_t;

  exp_t   exp_q[$];
  state_t m_st;

  moore_non dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .out   (out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference transition written from the state table, bit-first.
  function automatic state_t model_next(input state_t s, input logic b);
    state_t r;
    r = S0;
    if (b) begin
      if (s == S0) r = S1;
      else if (s == S1) r = S2;
      else if (s == S3) r = S4;
    end else begin
      if (s == S2) r = S3;
    end
    return r;
  endfunction

  // Drive one bit at the falling edge, queue the expectation, then compare after the rising edge.
  task automatic step(input string tag, input logic b, input logic exp_out);
    exp_t e;
    exp_t got;
    @(negedge clk);
    in   = b;
    m_st = model_next(m_st, b);
    e.out = exp_out;
    e.ps  = m_st;
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 3'd1, 3'd0);
    end else begin
      got = exp_q.pop_front();
      check({got.tag, "_out"}, {2'b00, out}, {2'b00, got.out});
      check({got.tag, "_ps"}, dut.ps, got.ps);
    end
  endtask

  // bits and outs are listed first-bit-in-MSB over n positions.
  task automatic run_seq(input string tag, input logic [15:0] bits, input logic [15:0] outs, input int n);
    for (int i = 0; i < n; i++) begin
      step($sformatf("%s[%0d]", tag, i), bits[n-1-i], outs[n-1-i]);
    end
  endtask

  initial begin
    logic b;
    reset = 1'b1;
    in    = 1'b0;
    m_st  = S0;

    // Reset held for 20 ns while in toggles.
    #2;
    for (int i = 0; i < 4; i++) begin
      in = ~in;
      #1;
      check($sformatf("rst_hold_out%0d", i), {2'b00, out}, 3'd0);
      check($sformatf("rst_hold_ps%0d", i), dut.ps, S0);
      #4;
    end
    @(negedge clk);
    reset = 1'b0;
    in    = 1'b0;

    run_seq("basic", 16'b1101_0, 16'b0001_0, 5);
    run_seq("nonovl", 16'b1101101, 16'b0001000, 7);
    run_seq("sync0", 16'b0, 16'b0, 1);
    run_seq("triple", 16'b11101, 16'b00000, 5);
    run_seq("sync1", 16'b0, 16'b0, 1);
    run_seq("five1", 16'b1111101, 16'b0000001, 7);
    run_seq("after", 16'b1, 16'b0, 1);
    run_seq("partial", 16'b1100_1101, 16'b0000_0001, 8);
    run_seq("s4exit", 16'b0, 16'b0, 1);

    // Asynchronous reset mid-cycle from S3.
    run_seq("pre_rst", 16'b110, 16'b000, 3);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_ps", dut.ps, S0);
    check("async_rst_out", {2'b00, out}, 3'd0);
    @(negedge clk);
    #1;
    check("rst_held_ps", dut.ps, S0);
    reset = 1'b0;
    m_st  = S0;
    run_seq("post_rst", 16'b1101, 16'b0001, 4);

    // Random regression; expected flag taken from the model state after each bit.
    for (int i = 0; i < 40; i++) begin
      state_t nxt;
      b   = (i % 9 == 8) ? 1'b0 : 1'($urandom_range(0, 1));
      nxt = model_next(m_st, b);
      step($sformatf("rand[%0d]", i), b, nxt == S4);
    end

    if (exp_q.size() != 0) check("queue_drained", 3'd0, 3'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
